// File: rtl/jump_ctl_if.sv
// jump_ctl_if: bundles the player-motion controller's button inputs and its
// registered position/state outputs.
//   master : button source (game input side / testbench)
//   slave  : jump_ctl itself
// Signals:
//   jump_btn, left_btn, right_btn : raw asynchronous buttons into jump_ctl
//   xpos, ypos [11:0]  : player position (unsigned, y grows downward)
//   state [1:0]        : 0 IDLE, 1 CHARGE, 2 AIR, 3 LAND
//   charge [5:0]       : current charge level
//   velocity [11:0]    : signed vertical velocity, positive is upward
//   tick               : one-cycle physics tick strobe
// There is no valid/ready pair: outputs are always valid, and they change
// only on the cycle after tick is high.
interface jump_ctl_if;
  logic        jump_btn;
  logic        left_btn;
  logic        right_btn;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic [1:0]  state;
  logic [5:0]  charge;
  logic [11:0] velocity;
  logic        tick;

  modport master (
    output jump_btn, left_btn, right_btn,
    input  xpos, ypos, state, charge, velocity, tick
  );

  modport slave (
    input  jump_btn, left_btn, right_btn,
    output xpos, ypos, state, charge, velocity, tick
  );
endinterface

// File: rtl/jump_ctl.sv
// jump_ctl: tick-driven player-motion controller. Sequences charge, launch,
// flight and landing of a jump, integrates vertical velocity under gravity
// and clamps the player against ground, ceiling and side walls.
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active-high
//   bus  : jump_ctl_if.slave (buttons in, position/state/charge/velocity/tick out)
// Optional feature macro: JUMP_WALL_BOUNCE_EN
//   defined   -> a wall hit in flight negates the horizontal direction
//   undefined -> a wall hit in flight clears the horizontal direction
module jump_ctl #(
  parameter int TICK_CYCLES = 1_000_000,
  parameter int GROUND_Y    = 537,
  parameter int X_MAX       = 1023,
  parameter int START_X     = 512,
  parameter int MAX_CHARGE  = 40,
  parameter int V_GAIN      = 2,
  parameter int GRAVITY     = 1,
  parameter int MAX_FALL    = 20,
  parameter int H_SPEED     = 3,
  parameter int WALK_SPEED  = 1
) (
  input logic      clk,
  input logic      rst,
  jump_ctl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHARGE = 2'd1,
    ST_AIR    = 2'd2,
    ST_LAND   = 2'd3
  } state_t;

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TICK_CYCLES - 1);
  localparam logic signed [12:0] GROUND_S  = 13'(GROUND_Y);
  localparam logic signed [12:0] X_MAX_S   = 13'(X_MAX);
  localparam logic signed [12:0] H_S       = 13'(H_SPEED);
  localparam logic signed [12:0] W_S       = 13'(WALK_SPEED);
  localparam logic signed [12:0] G_S       = 13'(GRAVITY);
  localparam logic signed [12:0] FALL_S    = 13'(-MAX_FALL);
  localparam logic signed [12:0] VGAIN_S   = 13'(V_GAIN);
  localparam logic [5:0]         MAX_CHG   = 6'(MAX_CHARGE);
  localparam logic [11:0]        START_X_U = 12'(START_X);
  localparam logic [11:0]        GROUND_U  = 12'(GROUND_Y);
  localparam logic [11:0]        X_MAX_U   = 12'(X_MAX);

  // Registers
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic [2:0]         sync1_q, sync2_q;   // {jump, left, right}
  state_t             state_q, state_d;
  logic [11:0]        x_q, x_d;
  logic [11:0]        y_q, y_d;
  logic [5:0]         charge_q, charge_d;
  logic signed [12:0] vel_q, vel_d;
  logic signed [1:0]  dir_q, dir_d;

  // Synchronised buttons and derived physics terms
  logic               jmp, lft, rgt;
  logic signed [1:0]  walk_dir;
  logic signed [12:0] x_s, x_walk, x_air, y_next, vel_grav, vel_fall, vel_launch;
  logic [5:0]         charge_eff;
  logic               hit_ceiling, hit_ground, hit_wall;

  function automatic logic [11:0] clamp_x(input logic signed [12:0] v);
    if (v < 13'sd0)         return 12'd0;
    else if (v > X_MAX_S)   return X_MAX_U;
    else                    return v[11:0];
  endfunction

  assign jmp = sync2_q[2];
  assign lft = sync2_q[1];
  assign rgt = sync2_q[0];

  // Exactly one direction held gives -1/+1; both or neither gives 0.
  always_comb begin
    walk_dir = 2'sb00;
    if (lft && !rgt)      walk_dir = 2'sb11;
    else if (rgt && !lft) walk_dir = 2'sb01;
  end

  assign x_s    = $signed({1'b0, x_q});
  assign x_walk = (walk_dir == 2'sb01) ? x_s + W_S :
                  (walk_dir == 2'sb11) ? x_s - W_S : x_s;
  assign x_air  = (dir_q == 2'sb01) ? x_s + H_S :
                  (dir_q == 2'sb11) ? x_s - H_S : x_s;
  assign y_next   = $signed({1'b0, y_q}) - vel_q;
  assign vel_grav = vel_q - G_S;
  assign vel_fall = (vel_grav < FALL_S) ? FALL_S : vel_grav;
  // A release before the first increment still launches with one unit.
  assign charge_eff = (charge_q == 6'd0) ? 6'd1 : charge_q;
  assign vel_launch = $signed({7'b0, charge_eff}) * VGAIN_S;

  assign hit_ceiling = (y_next < 13'sd0);
  assign hit_ground  = (y_next >= GROUND_S);
  assign hit_wall    = (x_air < 13'sd0) || (x_air > X_MAX_S);

  // Tick divider: tick_q is high for one cycle each time the counter wraps.
  always_comb begin
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + CNT_W'(1);
      tick_d = 1'b0;
    end
  end

  // State register (all sequential state)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      state_q  <= ST_IDLE;
      x_q      <= START_X_U;
      y_q      <= GROUND_U;
      charge_q <= '0;
      vel_q    <= '0;
      dir_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      sync1_q  <= {bus.jump_btn, bus.left_btn, bus.right_btn};
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      charge_q <= charge_d;
      vel_q    <= vel_d;
      dir_q    <= dir_d;
    end
  end

  // Next-state logic: transitions only on tick cycles.
  always_comb begin
    state_d = state_q;
    if (tick_q) begin
      case (state_q)
        ST_IDLE:   if (jmp) state_d = ST_CHARGE;
        ST_CHARGE: if (!jmp || charge_q >= MAX_CHG) state_d = ST_AIR;
        ST_AIR:    if (hit_ground) state_d = ST_LAND;
        ST_LAND:   if (!jmp) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath / output logic: position, charge, velocity, direction.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    charge_d = charge_q;
    vel_d    = vel_q;
    dir_d    = dir_q;
    if (tick_q) begin
      case (state_q)
        ST_IDLE: begin
          if (jmp) charge_d = '0;
          else     x_d = clamp_x(x_walk);
        end
        ST_CHARGE: begin
          if (jmp && charge_q < MAX_CHG) begin
            charge_d = charge_q + 6'd1;
          end else begin
            vel_d    = vel_launch;
            dir_d    = walk_dir;
            charge_d = '0;
          end
        end
        ST_AIR: begin
          vel_d = vel_fall;
          y_d   = y_next[11:0];
          if (hit_ceiling) begin
            y_d   = '0;
            vel_d = '0;
          end
          if (hit_ground) begin
            y_d   = GROUND_U;
            vel_d = '0;
          end
          x_d = clamp_x(x_air);
          if (hit_wall) begin
`ifdef JUMP_WALL_BOUNCE_EN
            dir_d = -dir_q;
`else
            dir_d = 2'sb00;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.xpos     = x_q;
  assign bus.ypos     = y_q;
  assign bus.state    = state_q;
  assign bus.charge   = charge_q;
  assign bus.velocity = vel_q[11:0];
  assign bus.tick     = tick_q;

endmodule
